// File: rtl/mute_pkg.sv
// Shared types and helpers for the click-free mute sequencer.
// Holds the sequencer state encoding, the sample width and the gain helper functions.
// Optional feature macro: MUTE_SEQ_ZEROCROSS_EN (adds the WAIT_ZC state encoding use).
package mute_pkg;

    localparam int SAMPLE_W = 32;

    // ST_WAIT_ZC is only reachable when MUTE_SEQ_ZEROCROSS_EN is defined.
    typedef enum logic [2:0] {
        ST_UNMUTED   = 3'd0,
        ST_RAMP_DOWN = 3'd1,
        ST_MUTED     = 3'd2,
        ST_RAMP_UP   = 3'd3,
        ST_WAIT_ZC   = 3'd4
    } mute_state_t;

    // Unity gain: the MSB of an unsigned GAIN_W-bit word.
    function automatic int gain_unity(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

    // Per-sample ramp step so that a full ramp takes exactly ramp_len samples.
    function automatic int gain_step(input int gain_w, input int ramp_len);
        return gain_unity(gain_w) / ramp_len;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Purpose: 2-FF synchronizer plus debounce counter for the raw mute switch.
// Latency: an edge on sw_async reaches req after 2 sync cycles plus DEBOUNCE_CYCLES stable cycles.
// Ports: clk, rst_n (async active-low), sw_async (raw switch), req (debounced level, resets to 0).
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic req
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;   // last synchronized value, for change detection
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;

    always_comb begin
        sync_d   = {sync_q[0], sw_async};
        stable_d = sync_q[1];
        cnt_d    = cnt_q;
        req_d    = req_q;
        if (sync_q[1] != stable_q) begin
            // Any change restarts the stability window; the change cycle itself is stable cycle 1.
            cnt_d = CNT_W'(DEBOUNCE_CYCLES - 1);
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            // Copy on the last stable cycle so req moves exactly DEBOUNCE_CYCLES after sync.
            if (cnt_q <= CNT_W'(1)) begin
                req_d = stable_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
        end
    end

    assign req = req_q;

endmodule

// File: rtl/mute_sequencer.sv
// Purpose: debounced mute switch drives a linear per-sample gain ramp; mute stage enabled only at silence.
// Latency: 1 clock from sample_valid to out_valid/out_L/out_R; outputs hold between strobes.
// Ports: clk, rst_n, sw_mute, sample_valid, in_L/in_R -> out_L/out_R, out_valid, gain, mute_active, busy.
// Optional feature macro: MUTE_SEQ_ZEROCROSS_EN (wait for an in_L zero crossing before ramping).
module mute_sequencer
    import mute_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RAMP_LEN        = 256,
    parameter int GAIN_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sw_mute,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] in_L,
    input  logic signed [SAMPLE_W-1:0] in_R,
    output logic signed [SAMPLE_W-1:0] out_L,
    output logic signed [SAMPLE_W-1:0] out_R,
    output logic                       out_valid,
    output logic [GAIN_W-1:0]          gain,
    output logic                       mute_active,
    output logic                       busy
);

    localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(gain_unity(GAIN_W));
    localparam logic [GAIN_W-1:0] STEP   = GAIN_W'(gain_step(GAIN_W, RAMP_LEN));
    localparam int                PROD_W = SAMPLE_W + GAIN_W + 1;

    logic req;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_async(sw_mute),
        .req     (req)
    );

    mute_state_t                state_q, state_d;
    logic [GAIN_W-1:0]          gain_q, gain_d;
    logic signed [SAMPLE_W-1:0] out_l_q, out_l_d;
    logic signed [SAMPLE_W-1:0] out_r_q, out_r_d;
    logic                       out_valid_q, out_valid_d;

`ifdef MUTE_SEQ_ZEROCROSS_EN
    localparam int ZC_W = $clog2(RAMP_LEN) + 1;

    logic            zc_from_muted_q, zc_from_muted_d;  // origin of the current WAIT_ZC visit
    logic [ZC_W-1:0] zc_cnt_q, zc_cnt_d;                // strobes spent in WAIT_ZC
    logic            prev_sign_q, prev_sign_d;          // sign of in_L on the previous strobe
    logic            zc_hit;

    assign zc_hit = (in_L == '0) || (in_L[SAMPLE_W-1] != prev_sign_q);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_UNMUTED;
            gain_q          <= UNITY;
            out_l_q         <= '0;
            out_r_q         <= '0;
            out_valid_q     <= 1'b0;
`ifdef MUTE_SEQ_ZEROCROSS_EN
            zc_from_muted_q <= 1'b0;
            zc_cnt_q        <= '0;
            prev_sign_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gain_q          <= gain_d;
            out_l_q         <= out_l_d;
            out_r_q         <= out_r_d;
            out_valid_q     <= out_valid_d;
`ifdef MUTE_SEQ_ZEROCROSS_EN
            zc_from_muted_q <= zc_from_muted_d;
            zc_cnt_q        <= zc_cnt_d;
            prev_sign_q     <= prev_sign_d;
`endif
        end
    end

    // ---------------- next-state / gain ----------------
    // The gain step always follows the direction of the current state, so a req change
    // landing on a strobe cycle only redirects the ramp from the next cycle on.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
`ifdef MUTE_SEQ_ZEROCROSS_EN
        zc_from_muted_d = zc_from_muted_q;
        zc_cnt_d        = zc_cnt_q;
        prev_sign_d     = sample_valid ? in_L[SAMPLE_W-1] : prev_sign_q;
`endif
        case (state_q)
            ST_UNMUTED: begin
                if (req) begin
`ifdef MUTE_SEQ_ZEROCROSS_EN
                    state_d         = ST_WAIT_ZC;
                    zc_from_muted_d = 1'b0;
                    zc_cnt_d        = '0;
`else
                    state_d = ST_RAMP_DOWN;
`endif
                end
            end
            ST_RAMP_DOWN: begin
                if (sample_valid) begin
                    gain_d = gain_q - STEP;
                end
                if (sample_valid && (gain_q == STEP)) begin
                    state_d = ST_MUTED;
                end else if (!req) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_MUTED: begin
                if (!req) begin
`ifdef MUTE_SEQ_ZEROCROSS_EN
                    state_d         = ST_WAIT_ZC;
                    zc_from_muted_d = 1'b1;
                    zc_cnt_d        = '0;
`else
                    state_d = ST_RAMP_UP;
`endif
                end
            end
            ST_RAMP_UP: begin
                if (sample_valid) begin
                    gain_d = gain_q + STEP;
                end
                if (sample_valid && (gain_q == UNITY - STEP)) begin
                    state_d = ST_UNMUTED;
                end else if (req) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
`ifdef MUTE_SEQ_ZEROCROSS_EN
            ST_WAIT_ZC: begin
                // req back at its pre-entry level means the request was withdrawn.
                if (req == zc_from_muted_q) begin
                    state_d = zc_from_muted_q ? ST_MUTED : ST_UNMUTED;
                end else if (sample_valid &&
                             (zc_hit || (zc_cnt_q == ZC_W'(RAMP_LEN - 1)))) begin
                    state_d = zc_from_muted_q ? ST_RAMP_UP : ST_RAMP_DOWN;
                end else if (sample_valid) begin
                    zc_cnt_d = zc_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_UNMUTED;
            end
        endcase
    end

    // ---------------- datapath ----------------
    // Product uses the gain held before this strobe's update; arithmetic shift floors toward -inf.
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod_l, prod_r;

    always_comb begin
        gain_ext    = PROD_W'($signed({1'b0, gain_q}));
        prod_l      = PROD_W'(in_L) * gain_ext;
        prod_r      = PROD_W'(in_R) * gain_ext;
        out_valid_d = sample_valid;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        if (sample_valid) begin
            out_l_d = SAMPLE_W'(prod_l >>> (GAIN_W - 1));
            out_r_d = SAMPLE_W'(prod_r >>> (GAIN_W - 1));
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mute_active = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_MUTED: begin
                mute_active = 1'b1;
            end
            ST_RAMP_DOWN, ST_RAMP_UP: begin
                busy = 1'b1;
            end
`ifdef MUTE_SEQ_ZEROCROSS_EN
            ST_WAIT_ZC: begin
                busy        = 1'b1;
                // Still silent while waiting to leave MUTED, so keep the mute stage engaged.
                mute_active = zc_from_muted_q;
            end
`endif
            default: begin
            end
        endcase
    end

    assign out_L     = out_l_q;
    assign out_R     = out_r_q;
    assign out_valid = out_valid_q;
    assign gain      = gain_q;

endmodule

// File: tb/tb_mute_sequencer.sv
module tb_mute_sequencer;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic               sw_mute      = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [31:0] in_L         = '0;
    logic signed [31:0] in_R         = '0;
    logic signed [31:0] out_L;
    logic signed [31:0] out_R;
    logic               out_valid;
    logic [15:0]        gain;
    logic               mute_active;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_l_q[$];
    logic [31:0] exp_r_q[$];

    mute_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .RAMP_LEN       (4),
        .GAIN_W         (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_mute     (sw_mute),
        .sample_valid(sample_valid),
        .in_L        (in_L),
        .in_R        (in_R),
        .out_L       (out_L),
        .out_R       (out_R),
        .out_valid   (out_valid),
        .gain        (gain),
        .mute_active (mute_active),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sample strobe; the expected output pair goes to the scoreboard.
    task automatic strobe(input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] el, input logic [31:0] er);
        sample_valid = 1'b1;
        in_L         = l;
        in_R         = r;
        exp_l_q.push_back(el);
        exp_r_q.push_back(er);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // With zero-cross gating, an in_L of 0 releases WAIT_ZC immediately without a gain step.
    task automatic enter_ramp();
`ifdef MUTE_SEQ_ZEROCROSS_EN
        strobe(32'h0, 32'h0, 32'h0, 32'h0);
`endif
    endtask

    // Scoreboard monitor: samples away from the active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_l_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no output");
            end else begin
                check("out_L", out_L, exp_l_q.pop_front());
                check("out_R", out_R, exp_r_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_gain", 32'(gain), 32'h8000);
        check("rst_out_L", out_L, 32'h0);
        check("rst_out_R", out_R, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_mute_active", 32'(mute_active), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Unity gain passes data bit-exactly
        strobe(32'h12345678, 32'h87654321, 32'h12345678, 32'h87654321);
        check("unity_out_valid", 32'(out_valid), 32'h1);
        check("unity_gain", 32'(gain), 32'h8000);
        tick(1);
        check("unity_valid_drop", 32'(out_valid), 32'h0);
        check("unity_hold", out_L, 32'h12345678);

        // Bounce rejection: toggle every 4 clocks for 40 clocks
        for (int i = 0; i < 10; i++) begin
            sw_mute = ~sw_mute;
            for (int j = 0; j < 4; j++) begin
                tick(1);
                check("bounce_busy", 32'(busy), 32'h0);
                check("bounce_gain", 32'(gain), 32'h8000);
            end
        end
        tick(20);
        check("bounce_settled_busy", 32'(busy), 32'h0);
        check("bounce_settled_gain", 32'(gain), 32'h8000);

        // Mute ramp, back-to-back strobes
        sw_mute = 1'b1;
        tick(14);
        check("down_busy", 32'(busy), 32'h1);
        enter_ramp();
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        check("down_gain1", 32'(gain), 32'h6000);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        check("down_gain2", 32'(gain), 32'h4000);
        strobe(32'h40000000, 32'hC0000000, 32'h20000000, 32'hE0000000);
        check("down_gain3", 32'(gain), 32'h2000);
        check("down_mute_early", 32'(mute_active), 32'h0);
        strobe(32'h40000000, 32'hC0000000, 32'h10000000, 32'hF0000000);
        check("down_gain4", 32'(gain), 32'h0);
        check("down_mute_active", 32'(mute_active), 32'h1);
        check("muted_busy", 32'(busy), 32'h0);
        tick(2);
        strobe(32'h40000000, 32'hC0000000, 32'h0, 32'h0);
        check("muted_gain", 32'(gain), 32'h0);

        // Ramp back up from silence
        sw_mute = 1'b0;
        tick(14);
        enter_ramp();
        check("up_mute_clear", 32'(mute_active), 32'h0);
        check("up_busy", 32'(busy), 32'h1);
        strobe(32'h40000000, 32'hC0000000, 32'h0, 32'h0);
        check("up_gain1", 32'(gain), 32'h2000);
        strobe(32'h40000000, 32'hC0000000, 32'h10000000, 32'hF0000000);
        strobe(32'h40000000, 32'hC0000000, 32'h20000000, 32'hE0000000);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        check("up_gain_unity", 32'(gain), 32'h8000);
        check("up_done_busy", 32'(busy), 32'h0);

        // Reversal after two down-steps
        sw_mute = 1'b1;
        tick(14);
        enter_ramp();
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        check("rev_gain_mid", 32'(gain), 32'h4000);
        sw_mute = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("rev_wait_gain", 32'(gain), 32'h4000);
            check("rev_wait_mute", 32'(mute_active), 32'h0);
        end
        strobe(32'h40000000, 32'hC0000000, 32'h20000000, 32'hE0000000);
        check("rev_gain_up1", 32'(gain), 32'h6000);
        check("rev_mute1", 32'(mute_active), 32'h0);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        check("rev_gain_up2", 32'(gain), 32'h8000);
        check("rev_mute2", 32'(mute_active), 32'h0);
        check("rev_busy", 32'(busy), 32'h0);

        // Reset asserted mid-ramp
        sw_mute = 1'b1;
        tick(14);
        enter_ramp();
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        tick(1);
        check("midrst_pre_gain", 32'(gain), 32'h4000);
        check("midrst_pre_busy", 32'(busy), 32'h1);
        rst_n   = 1'b0;
        sw_mute = 1'b0;
        #1;
        check("midrst_gain", 32'(gain), 32'h8000);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_mute", 32'(mute_active), 32'h0);
        check("midrst_out_L", out_L, 32'h0);
        check("midrst_out_R", out_R, 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

`ifdef MUTE_SEQ_ZEROCROSS_EN
        // Zero-cross gating: no step until in_L changes sign
        sw_mute = 1'b1;
        tick(14);
        check("zc_wait_busy", 32'(busy), 32'h1);
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        check("zc_hold1", 32'(gain), 32'h8000);
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        check("zc_hold2", 32'(gain), 32'h8000);
        strobe(32'hC0000000, 32'h40000000, 32'hC0000000, 32'h40000000);
        check("zc_cross_gain", 32'(gain), 32'h8000);
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        check("zc_first_step", 32'(gain), 32'h6000);
        sw_mute = 1'b0;
        tick(14);
        strobe(32'h40000000, 32'hC0000000, 32'h30000000, 32'hD0000000);
        check("zc_back_unity", 32'(gain), 32'h8000);
        // Timeout: constant positive input leaves WAIT_ZC after 4 strobes
        sw_mute = 1'b1;
        tick(14);
        for (int i = 0; i < 4; i++) begin
            strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
            check("zc_timeout_hold", 32'(gain), 32'h8000);
        end
        strobe(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000);
        check("zc_timeout_step", 32'(gain), 32'h6000);
        sw_mute = 1'b0;
`endif

        tick(3);
        check("scoreboard_drain", 32'(exp_l_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
